// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one cache-line memory port between ICache refill, DCache refill and DCache writeback.
// Latency: grant one cycle after request; reply pulse one cycle after mem_ready; 3-cycle minimum occupancy.
// Backpressure: requesters hold valid until their ready pulse; the memory transaction is held until mem_ready.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic                  i_ready,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_rvalid,
  input  logic [ADDR_WIDTH-1:0] d_raddr,
  output logic                  d_rready,
  output logic [LINE_WIDTH-1:0] d_rdata,
  input  logic                  d_wvalid,
  input  logic [ADDR_WIDTH-1:0] d_waddr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_wready,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  // Clears the byte-within-line bits so memory always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;
  typedef enum logic {RR_I, RR_D} rr_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  rr_t                   rr_last_q, rr_last_d;
  logic                  cancel_q, cancel_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0] resp_q, resp_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_rready_q, d_rready_d;
  logic                  d_wready_q, d_wready_d;

  // A flushed instruction request is not eligible for grant in the same cycle.
  logic i_req;
  assign i_req = i_valid & ~i_flush;

  // Arbitration, transaction tracking and reply-pulse generation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    cancel_d    = cancel_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_d      = resp_q;
    i_ready_d   = 1'b0;
    d_rready_d  = 1'b0;
    d_wready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_wvalid) begin
          // Writeback first so a dirty victim leaves before its set is refilled.
          owner_d     = OWN_DW;
          mem_we_d    = 1'b1;
          mem_addr_d  = d_waddr & LINE_MASK;
          mem_wdata_d = d_wdata;
          mem_valid_d = 1'b1;
          state_d     = ST_BUSY;
        end else if (i_req && (!d_rvalid || rr_last_q == RR_D)) begin
          owner_d     = OWN_I;
          rr_last_d   = RR_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr & LINE_MASK;
          mem_valid_d = 1'b1;
          state_d     = ST_BUSY;
        end else if (d_rvalid) begin
          owner_d     = OWN_DR;
          rr_last_d   = RR_D;
          mem_we_d    = 1'b0;
          mem_addr_d  = d_raddr & LINE_MASK;
          mem_valid_d = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The memory side cannot be aborted, so a flush only suppresses the reply.
        if (owner_q == OWN_I && i_flush) begin
          cancel_d = 1'b1;
        end
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ST_RESP;
          if (!cancel_d) begin
            resp_d     = mem_rdata;
            i_ready_d  = (owner_q == OWN_I);
            d_rready_d = (owner_q == OWN_DR);
            d_wready_d = (owner_q == OWN_DW);
          end
        end
      end
      ST_RESP: begin
        cancel_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      rr_last_q   <= RR_D;
      cancel_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= '0;
      i_ready_q   <= 1'b0;
      d_rready_q  <= 1'b0;
      d_wready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      cancel_q    <= cancel_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_q      <= resp_d;
      i_ready_q   <= i_ready_d;
      d_rready_q  <= d_rready_d;
      d_wready_q  <= d_wready_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_rready  = d_rready_q;
  assign d_wready  = d_wready_q;
  // Both refill paths read the same response line; only the owner's pulse qualifies it.
  assign i_rdata   = resp_q;
  assign d_rdata   = resp_q;

endmodule
